// File: rtl/load_store_unit.sv
// Data-memory access stage: formats loads/stores, runs a req/ack handshake with data memory,
// stalls the core while busy and reports faults and timeouts with a one-cycle done pulse.
module load_store_unit #(
  parameter int unsigned MaxWait = 15
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        start_i,
  input  logic        is_store_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] store_data_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] load_data_o,
  output logic        fault_o,
  output logic        timeout_err_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [3:0]  mem_wstrb_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i
);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  localparam logic [7:0] CntLast = 8'(MaxWait - 1);

  state_e      state_q, state_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [3:0]  mem_wstrb_q, mem_wstrb_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [1:0]  off_q, off_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        done_q, done_d;
  logic        fault_q, fault_d;
  logic        timeout_q, timeout_d;
  logic [31:0] load_data_q, load_data_d;

  logic        legal;
  logic [3:0]  st_wstrb;
  logic [31:0] st_wdata;
  logic [31:0] rd_shift;
  logic [31:0] ld_fmt;

  // Alignment and funct3 legality of the incoming request.
  always_comb begin
    legal = 1'b0;
    if (is_store_i) begin
      unique case (funct3_i)
        3'b000:  legal = 1'b1;
        3'b001:  legal = ~addr_i[0];
        3'b010:  legal = (addr_i[1:0] == 2'b00);
        default: legal = 1'b0;
      endcase
    end else begin
      unique case (funct3_i)
        3'b000, 3'b100: legal = 1'b1;
        3'b001, 3'b101: legal = ~addr_i[0];
        3'b010:         legal = (addr_i[1:0] == 2'b00);
        default:        legal = 1'b0;
      endcase
    end
  end

  always_comb begin
    st_wstrb = 4'b0000;
    st_wdata = 32'h0;
    if (is_store_i) begin
      unique case (funct3_i[1:0])
        2'b00: begin
          st_wstrb = 4'b0001 << addr_i[1:0];
          st_wdata = {4{store_data_i[7:0]}};
        end
        2'b01: begin
          st_wstrb = 4'b0011 << addr_i[1:0];
          st_wdata = {2{store_data_i[15:0]}};
        end
        default: begin
          st_wstrb = 4'b1111;
          st_wdata = store_data_i;
        end
      endcase
    end
  end

  // Bring the addressed byte/halfword down to bit 0 before extending.
  always_comb begin
    rd_shift = mem_rdata_i >> {off_q, 3'b000};
    unique case (funct3_q)
      3'b000:  ld_fmt = {{24{rd_shift[7]}}, rd_shift[7:0]};
      3'b001:  ld_fmt = {{16{rd_shift[15]}}, rd_shift[15:0]};
      3'b010:  ld_fmt = mem_rdata_i;
      3'b100:  ld_fmt = {24'h0, rd_shift[7:0]};
      3'b101:  ld_fmt = {16'h0, rd_shift[15:0]};
      default: ld_fmt = 32'h0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wstrb_d = mem_wstrb_q;
    mem_wdata_d = mem_wdata_q;
    off_d       = off_q;
    funct3_d    = funct3_q;
    cnt_d       = cnt_q;
    done_d      = 1'b0;
    fault_d     = fault_q;
    timeout_d   = timeout_q;
    load_data_d = load_data_q;

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          timeout_d   = 1'b0;
          load_data_d = 32'h0;
          if (legal) begin
            mem_req_d   = 1'b1;
            mem_we_d    = is_store_i;
            mem_addr_d  = {addr_i[31:2], 2'b00};
            mem_wstrb_d = st_wstrb;
            mem_wdata_d = st_wdata;
            off_d       = addr_i[1:0];
            funct3_d    = funct3_i;
            cnt_d       = 8'h0;
            fault_d     = 1'b0;
            state_d     = StWait;
          end else begin
            fault_d = 1'b1;
            done_d  = 1'b1;
            state_d = StResp;
          end
        end
      end
      StWait: begin
        // Ack on the final wait cycle takes precedence over the timeout.
        if (mem_ack_i) begin
          mem_req_d   = 1'b0;
          load_data_d = mem_we_q ? 32'h0 : ld_fmt;
          done_d      = 1'b1;
          state_d     = StResp;
        end else if (cnt_q == CntLast) begin
          mem_req_d   = 1'b0;
          timeout_d   = 1'b1;
          load_data_d = 32'h0;
          done_d      = 1'b1;
          state_d     = StResp;
        end else begin
          cnt_d = cnt_q + 8'h1;
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= StIdle;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'h0;
      mem_wstrb_q <= 4'h0;
      mem_wdata_q <= 32'h0;
      off_q       <= 2'b00;
      funct3_q    <= 3'b000;
      cnt_q       <= 8'h0;
      done_q      <= 1'b0;
      fault_q     <= 1'b0;
      timeout_q   <= 1'b0;
      load_data_q <= 32'h0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wstrb_q <= mem_wstrb_d;
      mem_wdata_q <= mem_wdata_d;
      off_q       <= off_d;
      funct3_q    <= funct3_d;
      cnt_q       <= cnt_d;
      done_q      <= done_d;
      fault_q     <= fault_d;
      timeout_q   <= timeout_d;
      load_data_q <= load_data_d;
    end
  end

  assign busy_o        = ((state_q == StIdle) & start_i) | (state_q == StWait);
  assign done_o        = done_q;
  assign load_data_o   = load_data_q;
  assign fault_o       = fault_q;
  assign timeout_err_o = timeout_q;
  assign mem_req_o     = mem_req_q;
  assign mem_we_o      = mem_we_q;
  assign mem_addr_o    = mem_addr_q;
  assign mem_wstrb_o   = mem_wstrb_q;
  assign mem_wdata_o   = mem_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit with hand-computed expectations.
module tb_load_store_unit;

  logic        clk_i = 1'b0;
  logic        reset_i = 1'b1;
  logic        start_i = 1'b0;
  logic        is_store_i = 1'b0;
  logic [2:0]  funct3_i = 3'b000;
  logic [31:0] addr_i = 32'h0;
  logic [31:0] store_data_i = 32'h0;
  logic        busy_o, done_o, fault_o, timeout_err_o;
  logic [31:0] load_data_o;
  logic        mem_req_o, mem_we_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic [3:0]  mem_wstrb_o;
  logic        mem_ack_i = 1'b0;
  logic [31:0] mem_rdata_i = 32'h0;

  load_store_unit #(.MaxWait(4)) u_dut (
    .clk_i         (clk_i),
    .reset_i       (reset_i),
    .start_i       (start_i),
    .is_store_i    (is_store_i),
    .funct3_i      (funct3_i),
    .addr_i        (addr_i),
    .store_data_i  (store_data_i),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .load_data_o   (load_data_o),
    .fault_o       (fault_o),
    .timeout_err_o (timeout_err_o),
    .mem_req_o     (mem_req_o),
    .mem_we_o      (mem_we_o),
    .mem_addr_o    (mem_addr_o),
    .mem_wstrb_o   (mem_wstrb_o),
    .mem_wdata_o   (mem_wdata_o),
    .mem_ack_i     (mem_ack_i),
    .mem_rdata_i   (mem_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  int n_cmp = 0;
  int n_err = 0;

  // Results of the most recent access
  int          r_done_cyc, r_busy, r_req, r_unstable;
  logic        r_we, r_fault, r_tmo, r_busy_done;
  logic [31:0] r_addr, r_wdata, r_ld;
  logic [3:0]  r_wstrb;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Starts an access in the current IDLE cycle; ack_at is the WAIT cycle (1-based) carrying the
  // ack, 0 for never. poke drives spurious start pulses while the access is outstanding.
  task automatic access(input logic st, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] sd, input logic [31:0] rd, input int ack_at,
                        input logic poke);
    bit got_req = 1'b0;
    r_done_cyc = -1; r_busy = 0; r_req = 0; r_unstable = 0;
    r_we = 1'b0; r_addr = 32'h0; r_wstrb = 4'h0; r_wdata = 32'h0;
    start_i = 1'b1; is_store_i = st; funct3_i = f3; addr_i = a; store_data_i = sd;
    #1;
    if (busy_o) r_busy++;
    tick();
    start_i = 1'b0;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      if (done_o) begin
        r_done_cyc = cyc;
        r_fault = fault_o; r_tmo = timeout_err_o; r_ld = load_data_o;
        #1;
        r_busy_done = busy_o;
        tick();
        return;
      end
      if (mem_req_o) begin
        if (!got_req) begin
          got_req = 1'b1;
          r_we = mem_we_o; r_addr = mem_addr_o; r_wstrb = mem_wstrb_o; r_wdata = mem_wdata_o;
        end else if (mem_we_o !== r_we || mem_addr_o !== r_addr || mem_wstrb_o !== r_wstrb ||
                     mem_wdata_o !== r_wdata) begin
          r_unstable++;
        end
        r_req++;
      end
      mem_ack_i = (cyc == ack_at);
      mem_rdata_i = rd;
      if (poke) begin
        start_i = 1'b1; is_store_i = 1'b1; funct3_i = 3'b010; addr_i = 32'h200;
      end
      #1;
      if (busy_o) r_busy++;
      tick();
      mem_ack_i = 1'b0;
      start_i = 1'b0;
    end
  endtask

  initial begin
    tick();
    tick();
    check("rst_done", done_o, 0);
    check("rst_req", mem_req_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_ld", load_data_o, 0);
    check("rst_fault", fault_o, 0);
    check("rst_tmo", timeout_err_o, 0);
    check("rst_addr", mem_addr_o, 0);
    reset_i = 1'b0;
    tick();

    // LW, minimum latency
    access(1'b0, 3'b010, 32'h100, 32'h0, 32'hDEAD_BEEF, 1, 1'b0);
    check("lw_done_cyc", r_done_cyc, 2);
    check("lw_busy", r_busy, 2);
    check("lw_busy_done", r_busy_done, 0);
    check("lw_req", r_req, 1);
    check("lw_addr", r_addr, 32'h100);
    check("lw_we", r_we, 0);
    check("lw_ld", r_ld, 32'hDEAD_BEEF);
    check("lw_fault", r_fault, 0);
    check("lw_done_pulse", done_o, 0);
    check("lw_ld_hold", load_data_o, 32'hDEAD_BEEF);

    access(1'b0, 3'b000, 32'h103, 32'h0, 32'h80FF_0000, 1, 1'b0);
    check("lb_ld", r_ld, 32'hFFFF_FF80);
    access(1'b0, 3'b100, 32'h103, 32'h0, 32'h80FF_0000, 1, 1'b0);
    check("lbu_ld", r_ld, 32'h0000_0080);

    // SH upper half, ack on third wait cycle
    access(1'b1, 3'b001, 32'h102, 32'hABCD_1234, 32'h5555_5555, 3, 1'b0);
    check("sh_wstrb", r_wstrb, 4'b1100);
    check("sh_wdata", r_wdata, 32'h1234_1234);
    check("sh_addr", r_addr, 32'h100);
    check("sh_we", r_we, 1);
    check("sh_ld", r_ld, 0);
    check("sh_done_cyc", r_done_cyc, 4);
    check("sh_req", r_req, 3);
    check("sh_stable", r_unstable, 0);

    access(1'b1, 3'b000, 32'h101, 32'h0000_00A5, 32'h0, 1, 1'b0);
    check("sb_wstrb", r_wstrb, 4'b0010);
    check("sb_wdata", r_wdata, 32'hA5A5_A5A5);

    // Misaligned LW
    access(1'b0, 3'b010, 32'h101, 32'h0, 32'h0, 1, 1'b0);
    check("mis_req", r_req, 0);
    check("mis_done_cyc", r_done_cyc, 1);
    check("mis_fault", r_fault, 1);
    check("mis_busy", r_busy, 1);
    check("mis_fault_hold", fault_o, 1);

    access(1'b0, 3'b101, 32'h102, 32'h0, 32'h8001_0000, 1, 1'b0);
    check("lhu_fault", r_fault, 0);
    check("lhu_ld", r_ld, 32'h0000_8001);
    access(1'b0, 3'b001, 32'h102, 32'h0, 32'h8001_0000, 1, 1'b0);
    check("lh_ld", r_ld, 32'hFFFF_8001);

    access(1'b1, 3'b011, 32'h100, 32'h0, 32'h0, 1, 1'b0);
    check("st_f3_fault", r_fault, 1);
    access(1'b0, 3'b110, 32'h100, 32'h0, 32'h0, 1, 1'b0);
    check("ld_f3_fault", r_fault, 1);

    access(1'b0, 3'b010, 32'h100, 32'h0, 32'h1234_5678, 1, 1'b0);
    // Timeout with no ack
    access(1'b0, 3'b010, 32'h300, 32'h0, 32'hFFFF_FFFF, 0, 1'b0);
    check("tmo_req", r_req, 4);
    check("tmo_done_cyc", r_done_cyc, 5);
    check("tmo_err", r_tmo, 1);
    check("tmo_ld", r_ld, 0);

    // Ack on the last permitted wait cycle
    access(1'b0, 3'b010, 32'h300, 32'h0, 32'hCAFE_F00D, 4, 1'b0);
    check("edge_req", r_req, 4);
    check("edge_done_cyc", r_done_cyc, 5);
    check("edge_tmo", r_tmo, 0);
    check("edge_ld", r_ld, 32'hCAFE_F00D);

    // Reset while waiting, with start and ack also high
    start_i = 1'b1; is_store_i = 1'b1; funct3_i = 3'b010; addr_i = 32'h400;
    store_data_i = 32'h1111_2222;
    tick();
    start_i = 1'b0;
    check("rw_req_before", mem_req_o, 1);
    reset_i = 1'b1; start_i = 1'b1; mem_ack_i = 1'b1;
    tick();
    check("rw_req", mem_req_o, 0);
    check("rw_done", done_o, 0);
    check("rw_ld", load_data_o, 0);
    check("rw_we", mem_we_o, 0);
    check("rw_wstrb", mem_wstrb_o, 0);
    check("rw_wdata", mem_wdata_o, 0);
    check("rw_addr", mem_addr_o, 0);
    reset_i = 1'b0; start_i = 1'b0; mem_ack_i = 1'b0;
    tick();
    check("rw_no_done", done_o, 0);
    check("rw_idle_req", mem_req_o, 0);

    // LW after reset, with start pulses while busy
    access(1'b0, 3'b010, 32'h100, 32'h0, 32'h0BAD_F00D, 3, 1'b1);
    check("post_ld", r_ld, 32'h0BAD_F00D);
    check("post_we", r_we, 0);
    check("post_addr", r_addr, 32'h100);
    check("post_stable", r_unstable, 0);
    check("post_done_cyc", r_done_cyc, 4);
    check("post_idle_req", mem_req_o, 0);
    check("post_idle_busy", busy_o, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Multi-cycle data-memory access stage sitting directly downstream of the ALU in the single-cycle RISC-V core. It takes the ALU result as the effective address for loads and stores and runs a req/ack handshake with data memory. It formats byte, halfword and word stores and sign- or zero-extends loads. While an access is outstanding it stalls the core through `busy`, and it reports misaligned or illegal accesses and memory timeouts.

## Interface
- `MAX_WAIT`, 15: maximum number of WAIT cycles before timeout; legal range 1..255.

- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  access request from the execute stage; sampled only in IDLE.
- `is_store`  in  1  1 = store, 0 = load.
- `funct3`  in  3  RISC-V width/sign field: 000 B, 001 H, 010 W, 100 BU, 101 HU (loads only).
- `addr`  in  32  effective address, taken from ALU `ALU_Out`.
- `store_data`  in  32  rs2 value.
- `busy`  out  1  stall PC and register writeback (combinational).
- `done`  out  1  one-cycle completion pulse.
- `load_data`  out  32  formatted load result; valid when `done`=1.
- `fault`  out  1  misaligned or illegal funct3; valid with `done`.
- `timeout_err`  out  1  no ack within `MAX_WAIT`; valid with `done`.
- `mem_req`  out  1  memory request, held until ack or timeout.
- `mem_we`  out  1  write enable.
- `mem_addr`  out  32  word address, `{addr[31:2],2'b00}`.
- `mem_wstrb`  out  4  byte write strobes.
- `mem_wdata`  out  32  replicated store data.
- `mem_ack`  in  1  memory accept/complete, single cycle.
- `mem_rdata`  in  32  read word; valid when `mem_ack`=1.

## Operation
- States: IDLE, WAIT, RESP.
- **IDLE + start, legal access:**
  - Register `mem_addr`, `mem_we`, `mem_wstrb`, `mem_wdata`, plus offset `addr[1:0]` and funct3.
  - Set `mem_req`=1 and clear the wait counter.
  - Next state is WAIT.
- **IDLE + start, illegal access:** next state is RESP with `fault`=1. No `mem_req` is issued.
- **Illegal access conditions:**
  - H/HU/SH with `addr[0]`=1.
  - W with `addr[1:0]`≠0.
  - Load funct3 of 011, 110 or 111.
  - Store funct3 above 010.
- **WAIT + mem_ack:**
  - Deassert `mem_req`.
  - For loads, capture the formatted `mem_rdata` into `load_data`.
  - Next state is RESP.
- **WAIT without ack:**
  - Counter increments.
  - If the counter equals `MAX_WAIT`-1, deassert `mem_req`, set `timeout_err`=1, set `load_data`=0, and go to RESP.
  - An ack on the `MAX_WAIT`-th WAIT cycle wins over the timeout.
- **RESP:** `done`=1 for exactly one cycle, then IDLE. `fault`, `timeout_err` and `load_data` hold their values until the next `start` is accepted, which clears them.
- **Store formatting:**
  - SB: wdata = 4× `store_data[7:0]`, wstrb = 0001 << off.
  - SH: wdata = 2× `store_data[15:0]`, wstrb = 0011 << off.
  - SW: wdata = `store_data`, wstrb = 1111.
- **Load formatting:**
  - Byte = `mem_rdata[8*off+:8]`; halfword = `mem_rdata[8*off+:16]`.
  - B/H sign-extend; BU/HU zero-extend; W passes through.
  - Stores return `load_data`=0.
- **Busy:** `busy` = (IDLE & start) | WAIT. It is low in RESP, so the instruction retires on the `done` cycle.
- **Ignored inputs:**
  - `start` outside IDLE is ignored.
  - `mem_ack` outside WAIT is ignored.
  - `mem_*` outputs are stable throughout WAIT.
- **Reset:**
  - All outputs are 0 and the state is IDLE.
  - Reset in WAIT drops `mem_req` at that edge, and no `done` is issued.
  - Reset takes priority over `start` and `mem_ack`.

## Timing
- `start` sampled at edge T. `mem_req` is high from T+1.
- Ack sampled at edge T+k (k≥1). `done` is high during cycle T+k, through to edge T+k+1.
- Minimum access: `start` at cycle 0, req at cycle 1, ack at cycle 1, `done` at cycle 2. `busy` is high in cycles 0–1.
- Fault path: `done`+`fault` in the cycle after `start`, with `busy` high for one cycle.
- Timeout: `mem_req` is high for exactly `MAX_WAIT` cycles, and `done`+`timeout_err` follows in the next cycle.
- Back-to-back accesses: a new `start` is accepted in the first IDLE cycle after RESP. Throughput is at most one access per 3 cycles.
- All outputs except `busy` are registered.

## Test plan
- LW, addr 0x0000_0100, ack one cycle after req with rdata 0xDEAD_BEEF:
  - Required: `mem_addr`=0x100, `mem_we`=0, `done` 2 cycles after `start`, `load_data`=0xDEAD_BEEF, `busy` high for 2 cycles.
- LB and LBU, addr 0x103, rdata 0x80FF_0000:
  - Required: `load_data`=0xFFFF_FF80 for LB and 0x0000_0080 for LBU.
- SH, addr 0x102, `store_data` 0xABCD_1234, ack after 3 wait cycles:
  - Required: `mem_wstrb`=1100, `mem_wdata`=0x1234_1234, `mem_addr`=0x100, `load_data`=0.
- LW, addr 0x101:
  - Required: no `mem_req`; `done`=1 with `fault`=1 in the cycle after `start`.
  - Also check that LHU at 0x102 passes the alignment check.
- MAX_WAIT=4 with no ack:
  - Required: `mem_req` high for 4 cycles, then `done`+`timeout_err`=1 with `load_data`=0.
  - Repeat with ack on the 4th wait cycle: required is a normal completion with `timeout_err`=0.
- Reset asserted in WAIT:
  - Required: `mem_req`=0 and all outputs 0 after the edge, with no `done`.
  - A subsequent LW completes normally.
  - `start` pulses while busy are ignored.
